// File: rtl/ahb_apb_pkg.sv
// Shared encodings and defaults for the AHB side of the AHB-to-APB bridge.
package ahb_apb_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB responses
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Error-response FSM: the two-cycle ERROR response runs ERR1 then ERR2
    typedef logic [1:0] err_state_t;
    localparam err_state_t ST_OKAY = 2'd0;
    localparam err_state_t ST_ERR1 = 2'd1;
    localparam err_state_t ST_ERR2 = 2'd2;

    // Default peripheral region bases and region size (log2 bytes)
    localparam logic [31:0] DEF_BASE0       = 32'h8000_0000;
    localparam logic [31:0] DEF_BASE1       = 32'h8400_0000;
    localparam logic [31:0] DEF_BASE2       = 32'h8800_0000;
    localparam int          DEF_REGION_BITS = 26;

endpackage

// File: rtl/ahb_addr_decode.sv
// Maps an AHB address onto a one-hot select for one of three peripheral regions.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE0       = DEF_BASE0,
    parameter logic [31:0] BASE1       = DEF_BASE1,
    parameter logic [31:0] BASE2       = DEF_BASE2,
    parameter int          REGION_BITS = DEF_REGION_BITS
) (
    input  logic [31:0] i_haddr,
    output logic [2:0]  o_tempselx
);

    // Keeps only the bits above the region offset
    localparam logic [31:0] REGION_MASK = ~((32'd1 << REGION_BITS) - 32'd1);

    logic [31:0] w_addr_hi;

    assign w_addr_hi = i_haddr & REGION_MASK;

    // Compare the region field of the address with each base
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        o_tempselx = 3'b000;
        if (w_addr_hi == (BASE0 & REGION_MASK)) begin
            o_tempselx = 3'b001;
        end else if (w_addr_hi == (BASE1 & REGION_MASK)) begin
            o_tempselx = 3'b010;
        end else if (w_addr_hi == (BASE2 & REGION_MASK)) begin
            o_tempselx = 3'b100;
        end
    end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the bridge: address/data pipeline, transfer
// qualification and the two-cycle ERROR response for unmapped addresses.
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE0       = DEF_BASE0,
    parameter logic [31:0] BASE1       = DEF_BASE1,
    parameter logic [31:0] BASE2       = DEF_BASE2,
    parameter int          REGION_BITS = DEF_REGION_BITS
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    input  logic        Hreadyout,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Hready
);

    logic [2:0]  w_tempselx;
    logic        w_active;
    logic        w_unmapped;
    err_state_t  r_state;
    err_state_t  w_next_state;
    logic [31:0] r_haddr1;
    logic [31:0] r_haddr2;
    logic [31:0] r_hwdata1;
    logic [31:0] r_hwdata2;
    logic        r_hwrite;

    ahb_addr_decode #(
        .BASE0       (BASE0),
        .BASE1       (BASE1),
        .BASE2       (BASE2),
        .REGION_BITS (REGION_BITS)
    ) u_decode (
        .i_haddr    (Haddr),
        .o_tempselx (w_tempselx)
    );

    // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY never qualify or fault
    assign w_active   = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);
    assign w_unmapped = (w_tempselx == 3'b000);

    // Transfers arriving while an ERROR response is in flight are dropped
    assign valid     = Hreadyin && w_active && !w_unmapped && (r_state == ST_OKAY);
    assign tempselx  = w_tempselx;
    assign Hrdata    = Prdata;
    assign Haddr1    = r_haddr1;
    assign Haddr2    = r_haddr2;
    assign Hwdata1   = r_hwdata1;
    assign Hwdata2   = r_hwdata2;
    assign Hwritereg = r_hwrite;

    // Two-stage address/data pipeline that advances only when the bus is ready
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            // NOTE: clocked state uses <= so every flop samples pre-edge values; with = the stage-2 copy would see stage 1's new value.
            r_haddr1  <= '0;
            r_haddr2  <= '0;
            r_hwdata1 <= '0;
            r_hwdata2 <= '0;
            r_hwrite  <= 1'b0;
        end else if (Hreadyin) begin
            r_haddr1  <= Haddr;
            r_haddr2  <= r_haddr1;
            r_hwdata1 <= Hwdata;
            r_hwdata2 <= r_hwdata1;
            r_hwrite  <= Hwrite;
        end
    end

    // Next state: an active transfer to an unmapped address starts the ERROR response
    always_comb begin
        w_next_state = ST_OKAY;
        case (r_state)
            ST_OKAY: if (Hreadyin && w_active && w_unmapped) w_next_state = ST_ERR1;
            ST_ERR1: w_next_state = ST_ERR2;
            default: w_next_state = ST_OKAY;
        endcase
    end

    // Error FSM state register
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= ST_OKAY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Response outputs: ERROR takes one wait cycle then completes
    always_comb begin
        Hresp  = HRESP_OKAY;
        Hready = Hreadyout;
        case (r_state)
            ST_ERR1: begin
                Hresp  = HRESP_ERROR;
                Hready = 1'b0;
            end
            ST_ERR2: begin
                Hresp  = HRESP_ERROR;
                Hready = 1'b1;
            end
            default: begin
                Hresp  = HRESP_OKAY;
                Hready = Hreadyout;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Self-checking bench for ahb_slave_interface: directed scenarios plus a
// randomized run, all checked against a transaction-level model.
module tb_ahb_slave_interface;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Hreadyout;
    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: pipeline contents and cycles of ERROR response left
    logic [31:0] m_addr1 = '0, m_addr2 = '0, m_wd1 = '0, m_wd2 = '0;
    logic        m_wr = 1'b0;
    int          m_err_left = 0;

    ahb_slave_interface dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Hreadyout (Hreadyout),
        .valid     (valid),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata1   (Hwdata1),
        .Hwdata2   (Hwdata2),
        .Hwritereg (Hwritereg),
        .tempselx  (tempselx),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp),
        .Hready    (Hready)
    );

    always #5 Hclk = ~Hclk;

    // Region index = address divided by the 64 MiB region size
    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        int unsigned region = a / 32'h0400_0000;
        if (region == 32'h8000_0000 / 32'h0400_0000) return 3'b001;
        if (region == 32'h8400_0000 / 32'h0400_0000) return 3'b010;
        if (region == 32'h8800_0000 / 32'h0400_0000) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic is_transfer(input logic [1:0] t);
        return (t == 2'd2) || (t == 2'd3);
    endfunction

    function automatic logic exp_valid();
        return Hreadyin && is_transfer(Htrans) && (exp_sel(Haddr) != 3'b000) && (m_err_left == 0);
    endfunction

    function automatic logic [1:0] exp_hresp();
        return (m_err_left != 0) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic exp_hready();
        if (m_err_left == 2) return 1'b0;
        if (m_err_left == 1) return 1'b1;
        return Hreadyout;
    endfunction

    // Advance one clock and apply the same edge to the model; returns 1ns after the edge
    task automatic clock_edge();
        @(posedge Hclk);
        if (Hreset) begin
            m_addr1 = '0; m_addr2 = '0; m_wd1 = '0; m_wd2 = '0; m_wr = 1'b0;
            m_err_left = 0;
        end else begin
            if (Hreadyin) begin
                m_addr2 = m_addr1; m_addr1 = Haddr;
                m_wd2   = m_wd1;   m_wd1   = Hwdata;
                m_wr    = Hwrite;
            end
            if (m_err_left > 0) m_err_left = m_err_left - 1;
            else if (Hreadyin && is_transfer(Htrans) && exp_sel(Haddr) == 3'b000) m_err_left = 2;
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d, input logic rdy);
        Htrans = t; Haddr = a; Hwrite = w; Hwdata = d; Hreadyin = rdy;
    endtask

    task automatic test_reset();
        Hreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(2'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
            Prdata = $urandom; Hreadyout = 1'($urandom);
            clock_edge();
        end
        Hreset = 1'b0;
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        Hreadyout = 1'b1;
        #1;
        tests_run++; if (Haddr1 !== 32'h0) begin tests_failed++; $display("FAIL reset_haddr1: got %h expected 0", Haddr1); end
        tests_run++; if (Haddr2 !== 32'h0) begin tests_failed++; $display("FAIL reset_haddr2: got %h expected 0", Haddr2); end
        tests_run++; if (Hwdata1 !== 32'h0 || Hwdata2 !== 32'h0) begin tests_failed++; $display("FAIL reset_hwdata: got %h/%h expected 0/0", Hwdata1, Hwdata2); end
        tests_run++; if (Hwritereg !== 1'b0) begin tests_failed++; $display("FAIL reset_hwritereg: got %b expected 0", Hwritereg); end
        tests_run++; if (Hresp !== 2'b00) begin tests_failed++; $display("FAIL reset_hresp: got %b expected 00", Hresp); end
    endtask

    task automatic test_write_pipeline();
        drive(2'b10, 32'h8000_0010, 1'b1, 32'hA5A5_A5A5, 1'b1);
        Prdata = 32'h1234_5678; Hreadyout = 1'b0;
        #1;
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL write_valid: got %b expected 1", valid); end
        tests_run++; if (tempselx !== 3'b001) begin tests_failed++; $display("FAIL write_sel: got %b expected 001", tempselx); end
        tests_run++; if (Hrdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL write_hrdata: got %h expected 12345678", Hrdata); end
        tests_run++; if (Hready !== 1'b0) begin tests_failed++; $display("FAIL write_hready_pass: got %b expected 0", Hready); end
        clock_edge();
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        Hreadyout = 1'b1;
        #1;
        tests_run++; if (Haddr1 !== 32'h8000_0010) begin tests_failed++; $display("FAIL write_haddr1: got %h expected 80000010", Haddr1); end
        tests_run++; if (Hwritereg !== 1'b1) begin tests_failed++; $display("FAIL write_hwritereg: got %b expected 1", Hwritereg); end
        tests_run++; if (Hwdata1 !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL write_hwdata1: got %h expected a5a5a5a5", Hwdata1); end
        tests_run++; if (Haddr2 === 32'h8000_0010) begin tests_failed++; $display("FAIL write_haddr2_early: got %h expected 0", Haddr2); end
        clock_edge();
        tests_run++; if (Haddr2 !== 32'h8000_0010) begin tests_failed++; $display("FAIL write_haddr2: got %h expected 80000010", Haddr2); end
        tests_run++; if (Hwdata2 !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL write_hwdata2: got %h expected a5a5a5a5", Hwdata2); end
    endtask

    task automatic test_hold();
        logic [31:0] a1, a2;
        drive(2'b10, 32'h8400_0020, 1'b1, 32'hDEAD_BEEF, 1'b1);
        clock_edge();
        a1 = m_addr1; a2 = m_addr2;
        drive(2'b10, 32'h8800_0040, 1'b0, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL hold_valid: got %b expected 0", valid); end
            clock_edge();
        end
        tests_run++; if (Haddr1 !== a1) begin tests_failed++; $display("FAIL hold_haddr1: got %h expected %h", Haddr1, a1); end
        tests_run++; if (Haddr2 !== a2) begin tests_failed++; $display("FAIL hold_haddr2: got %h expected %h", Haddr2, a2); end
        tests_run++; if (Hwritereg !== 1'b1) begin tests_failed++; $display("FAIL hold_hwritereg: got %b expected 1", Hwritereg); end
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        clock_edge();
    endtask

    task automatic test_error();
        Hreadyout = 1'b1;
        drive(2'b10, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
        #1;
        tests_run++; if (tempselx !== 3'b000) begin tests_failed++; $display("FAIL err_sel: got %b expected 000", tempselx); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL err_valid: got %b expected 0", valid); end
        clock_edge();
        // A mapped transfer offered during ERR1 must be ignored
        drive(2'b10, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        #1;
        tests_run++; if (Hresp !== 2'b01 || Hready !== 1'b0) begin tests_failed++; $display("FAIL err1_resp: got %b/%b expected 01/0", Hresp, Hready); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL err1_valid: got %b expected 0", valid); end
        clock_edge();
        // An unmapped transfer offered during ERR2 must not restart the error
        drive(2'b11, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
        #1;
        tests_run++; if (Hresp !== 2'b01 || Hready !== 1'b1) begin tests_failed++; $display("FAIL err2_resp: got %b/%b expected 01/1", Hresp, Hready); end
        clock_edge();
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        Hreadyout = 1'b0;
        #1;
        tests_run++; if (Hresp !== 2'b00 || Hready !== 1'b0) begin tests_failed++; $display("FAIL err_done_resp: got %b/%b expected 00/0", Hresp, Hready); end
        clock_edge();
        tests_run++; if (Hresp !== 2'b00) begin tests_failed++; $display("FAIL err_no_retrigger: got %b expected 00", Hresp); end
        Hreadyout = 1'b1;
    endtask

    task automatic test_busy();
        drive(2'b01, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
        #1;
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL busy_valid: got %b expected 0", valid); end
        clock_edge();
        tests_run++; if (Hresp !== 2'b00) begin tests_failed++; $display("FAIL busy_hresp: got %b expected 00", Hresp); end
        drive(2'b00, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
        clock_edge();
        tests_run++; if (Hresp !== 2'b00) begin tests_failed++; $display("FAIL idle_hresp: got %b expected 00", Hresp); end
    endtask

    task automatic test_reset_in_err1();
        Hreadyout = 1'b1;
        drive(2'b10, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
        clock_edge();
        tests_run++; if (Hresp !== 2'b01) begin tests_failed++; $display("FAIL rst_err1_entry: got %b expected 01", Hresp); end
        Hreset = 1'b1;
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        clock_edge();
        Hreset = 1'b0;
        #1;
        tests_run++; if (Hresp !== 2'b00 || Hready !== 1'b1) begin tests_failed++; $display("FAIL rst_err1_abort: got %b/%b expected 00/1", Hresp, Hready); end
        drive(2'b10, 32'h8800_0004, 1'b0, 32'h0, 1'b1);
        #1;
        tests_run++; if (tempselx !== 3'b100) begin tests_failed++; $display("FAIL rst_read_sel: got %b expected 100", tempselx); end
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL rst_read_valid: got %b expected 1", valid); end
        clock_edge();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000 | ($urandom & 32'h03FF_FFFF);
                1: a = 32'h8400_0000 | ($urandom & 32'h03FF_FFFF);
                2: a = 32'h8800_0000 | ($urandom & 32'h03FF_FFFF);
                3: a = 32'h7FFF_FFFC;
                4: a = 32'h8C00_0000;
                default: a = $urandom;
            endcase
            Hreset = ($urandom_range(0, 39) == 0);
            drive(2'($urandom), a, 1'($urandom), $urandom, ($urandom_range(0, 4) != 0));
            Prdata = $urandom; Hreadyout = 1'($urandom);
            #1;
            tests_run++;
            if (tempselx !== exp_sel(Haddr) || valid !== exp_valid() || Hresp !== exp_hresp() ||
                Hready !== exp_hready() || Hrdata !== Prdata) begin
                tests_failed++;
                $display("FAIL rnd_comb[%0d]: got sel=%b valid=%b resp=%b rdy=%b rdata=%h expected sel=%b valid=%b resp=%b rdy=%b rdata=%h",
                         i, tempselx, valid, Hresp, Hready, Hrdata,
                         exp_sel(Haddr), exp_valid(), exp_hresp(), exp_hready(), Prdata);
            end
            clock_edge();
            tests_run++;
            if (Haddr1 !== m_addr1 || Haddr2 !== m_addr2 || Hwdata1 !== m_wd1 || Hwdata2 !== m_wd2 || Hwritereg !== m_wr) begin
                tests_failed++;
                $display("FAIL rnd_pipe[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                         i, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, m_addr1, m_addr2, m_wd1, m_wd2, m_wr);
            end
        end
        Hreset = 1'b0;
    endtask

    initial begin
        Hreset = 1'b1;
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        Prdata = '0; Hreadyout = 1'b1;
        test_reset();
        test_write_pipeline();
        test_hold();
        test_error();
        test_busy();
        test_reset_in_err1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
